// File: rtl/biquad_seq_ctrl.sv
// Sequencer for the shared MAC datapath of the IIR biquad: five timed MAC steps per sample.
// Optional sticky overrun flag and clear_ovr input under `BIQUAD_CTRL_OVERRUN_EN.
module biquad_seq_ctrl #(
   parameter int STEP_CYC = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
`ifdef BIQUAD_CTRL_OVERRUN_EN
   input  logic       clear_ovr,
`endif
   output logic [2:0] controlS,
   output logic [1:0] controlC,
   output logic [2:0] controlZ,
   output logic       en_uk,
   output logic       en_acum1,
   output logic       en_acum2,
   output logic       en_acum3,
   output logic       en_fk,
   output logic       en_yk,
   output logic       shift_en,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   typedef enum logic [3:0] {
      IDLE, CAPTURE, S0, S1, S2, S3, S4, UPDATE, DONE
   } state_t;

   localparam logic [3:0] LAST = 4'(STEP_CYC - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] sel_s_q, sel_s_d, sel_z_q, sel_z_d;
   logic [1:0] sel_c_q, sel_c_d;
   logic       en_uk_q, en_uk_d, en_a1_q, en_a1_d, en_a2_q, en_a2_d, en_a3_q, en_a3_d;
   logic       en_fk_q, en_fk_d, en_yk_q, en_yk_d, shift_q, shift_d;
   logic       busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
   logic       step_end, last_d;

   // Next state and step counter; the counter restarts at 0 on every step entry.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      step_end = (cnt_q == LAST);
      case (state_q)
         IDLE:    if (start) state_d = CAPTURE;
         CAPTURE: begin state_d = S0; cnt_d = '0; end
         S0, S1, S2, S3, S4: begin
            if (step_end) begin
               cnt_d = '0;
               case (state_q)
                  S0:      state_d = S1;
                  S1:      state_d = S2;
                  S2:      state_d = S3;
                  S3:      state_d = S4;
                  default: state_d = UPDATE;
               endcase
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         UPDATE:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with it.
   always_comb begin
      last_d  = (cnt_d == LAST);
      sel_s_d = 3'b000;
      sel_c_d = 2'b00;
      sel_z_d = 3'b000;
      en_uk_d = 1'b0;
      en_a1_d = 1'b0;
      en_a2_d = 1'b0;
      en_a3_d = 1'b0;
      en_fk_d = 1'b0;
      en_yk_d = 1'b0;
      shift_d = 1'b0;
      done_d  = 1'b0;
      busy_d  = (state_d != IDLE);
      case (state_d)
         CAPTURE: en_uk_d = 1'b1;
         S0: begin sel_s_d = 3'b001; sel_c_d = 2'b01; sel_z_d = 3'b001; en_a1_d = last_d; end
         S1: begin
            sel_s_d = 3'b010; sel_c_d = 2'b10; sel_z_d = 3'b011;
            en_a2_d = last_d; en_fk_d = last_d;
         end
         S2: begin sel_s_d = 3'b011; sel_c_d = 2'b11; sel_z_d = 3'b000; en_a1_d = last_d; end
         S3: begin sel_s_d = 3'b100; sel_c_d = 2'b01; sel_z_d = 3'b011; en_a2_d = last_d; end
         S4: begin
            sel_s_d = 3'b101; sel_c_d = 2'b10; sel_z_d = 3'b100;
            en_a3_d = last_d; en_yk_d = last_d;
         end
         UPDATE:  shift_d = 1'b1;
         DONE:    done_d  = 1'b1;
         default: ;
      endcase
`ifdef BIQUAD_CTRL_OVERRUN_EN
      ovr_d = ovr_q;
      if (start && (state_q != IDLE))  ovr_d = 1'b1;
      else if (start && clear_ovr)     ovr_d = 1'b0;
`else
      ovr_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_s_q <= '0;
         sel_c_q <= '0;
         sel_z_q <= '0;
         en_uk_q <= 1'b0;
         en_a1_q <= 1'b0;
         en_a2_q <= 1'b0;
         en_a3_q <= 1'b0;
         en_fk_q <= 1'b0;
         en_yk_q <= 1'b0;
         shift_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_s_q <= sel_s_d;
         sel_c_q <= sel_c_d;
         sel_z_q <= sel_z_d;
         en_uk_q <= en_uk_d;
         en_a1_q <= en_a1_d;
         en_a2_q <= en_a2_d;
         en_a3_q <= en_a3_d;
         en_fk_q <= en_fk_d;
         en_yk_q <= en_yk_d;
         shift_q <= shift_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   assign controlS = sel_s_q;
   assign controlC = sel_c_q;
   assign controlZ = sel_z_q;
   assign en_uk    = en_uk_q;
   assign en_acum1 = en_a1_q;
   assign en_acum2 = en_a2_q;
   assign en_acum3 = en_a3_q;
   assign en_fk    = en_fk_q;
   assign en_yk    = en_yk_q;
   assign shift_en = shift_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign overrun  = ovr_q;

endmodule

// File: tb/tb_biquad_seq_ctrl.sv
// Directed bench for biquad_seq_ctrl: timing tables, ignored starts, mid-sequence reset,
// STEP_CYC=1 back-to-back, and a Q14 datapath co-sim against a direct-form-II model.
module tb_biquad_seq_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start0 = 1'b0, start1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
   logic [2:0] s0, z0, s1, z1;
   logic [1:0] c0, c1;
   logic uk0, a10, a20, a30, fk0, yk0, sh0, bz0, dn0, ov0;
   logic uk1, a11, a21, a31, fk1e, yk1, sh1, bz1, dn1, ov1;
   int pass_cnt = 0, tot_cnt = 0;

`ifdef BIQUAD_CTRL_OVERRUN_EN
   localparam logic OVR = 1'b1;
`else
   localparam logic OVR = 1'b0;
`endif

   always #5 clk = ~clk;

   biquad_seq_ctrl #(.STEP_CYC(2)) dut0 (
      .clk(clk), .reset(rst_n), .start(start0),
`ifdef BIQUAD_CTRL_OVERRUN_EN
      .clear_ovr(clr0),
`endif
      .controlS(s0), .controlC(c0), .controlZ(z0), .en_uk(uk0), .en_acum1(a10),
      .en_acum2(a20), .en_acum3(a30), .en_fk(fk0), .en_yk(yk0), .shift_en(sh0),
      .busy(bz0), .done(dn0), .overrun(ov0));

   biquad_seq_ctrl #(.STEP_CYC(1)) dut1 (
      .clk(clk), .reset(rst_n), .start(start1),
`ifdef BIQUAD_CTRL_OVERRUN_EN
      .clear_ovr(clr1),
`endif
      .controlS(s1), .controlC(c1), .controlZ(z1), .en_uk(uk1), .en_acum1(a11),
      .en_acum2(a21), .en_acum3(a31), .en_fk(fk1e), .en_yk(yk1), .shift_en(sh1),
      .busy(bz1), .done(dn1), .overrun(ov1));

   wire [17:0] obs0 = {s0, c0, z0, uk0, a10, a20, a30, fk0, yk0, sh0, bz0, dn0, ov0};
   wire [17:0] obs1 = {s1, c1, z1, uk1, a11, a21, a31, fk1e, yk1, sh1, bz1, dn1, ov1};

   // Expected outputs k cycles after an accepted start, from the step timing table.
   function automatic logic [17:0] exp_at(input int k, input int p, input logic ovr);
      logic [2:0] s, z;
      logic [1:0] c;
      logic u, e1, e2, e3, f, y, sh, b, d, l;
      int j;
      s = 0; z = 0; c = 0; u = 0; e1 = 0; e2 = 0; e3 = 0; f = 0; y = 0; sh = 0; b = 0; d = 0;
      if (k == 1) begin u = 1; b = 1; end
      else if (k >= 2 && k < 2 + 5*p) begin
         b = 1;
         j = (k - 2) / p;
         l = (((k - 2) % p) == p - 1);
         case (j)
            0: begin s = 3'd1; c = 2'd1; z = 3'd1; e1 = l; end
            1: begin s = 3'd2; c = 2'd2; z = 3'd3; e2 = l; f = l; end
            2: begin s = 3'd3; c = 2'd3; z = 3'd0; e1 = l; end
            3: begin s = 3'd4; c = 2'd1; z = 3'd3; e2 = l; end
            default: begin s = 3'd5; c = 2'd2; z = 3'd4; e3 = l; y = l; end
         endcase
      end
      else if (k == 2 + 5*p) begin sh = 1; b = 1; end
      else if (k == 3 + 5*p) begin d = 1; b = 1; end
      return {s, c, z, u, e1, e2, e3, f, y, sh, b, d, ovr};
   endfunction

   // Behavioural Q14 datapath steered only by dut0's selects and strobes.
   localparam longint A1 = 16957, A2 = -6026, B0 = 9841, B1 = -19677, B2 = 9841;
   longint uk_in = 0, uk_r, ac1, ac2, ac3, fk_r, fk1_r, fk2_r, yk_r, sum;

   always_comb begin
      longint cf, sm, ad;
      cf = 0; sm = 0; ad = 0;
      case (s0)
         3'd1: cf = A1; 3'd2: cf = A2; 3'd3: cf = B0; 3'd4: cf = B1; 3'd5: cf = B2;
         default: cf = 0;
      endcase
      case (c0)
         2'd1: sm = fk1_r; 2'd2: sm = fk2_r; 2'd3: sm = fk_r; default: sm = 0;
      endcase
      case (z0)
         3'd1: ad = uk_r; 3'd2: ad = yk_r; 3'd3: ad = ac1; 3'd4: ad = ac2; 3'd5: ad = ac3;
         default: ad = 0;
      endcase
      sum = ad + ((cf * sm) >>> 14);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uk_r <= 0; ac1 <= 0; ac2 <= 0; ac3 <= 0; fk_r <= 0; fk1_r <= 0; fk2_r <= 0; yk_r <= 0;
      end else begin
         if (uk0) uk_r <= uk_in;
         if (a10) ac1 <= sum;
         if (a20) ac2 <= sum;
         if (a30) ac3 <= sum;
         if (fk0) fk_r <= sum;
         if (yk0) yk_r <= sum;
         if (sh0) begin fk2_r <= fk1_r; fk1_r <= fk_r; end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         tot_cnt++;
         if (obs0 !== 18'd0) $display("FAIL reset_idle[%0d] got %h want %h", k, obs0, 18'd0);
         else pass_cnt++;
      end
   endtask

   task automatic test_single();
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         tot_cnt++;
         if (obs0 !== exp_at(k, 2, 1'b0))
            $display("FAIL single[%0d] got %h want %h", k, obs0, exp_at(k, 2, 1'b0));
         else pass_cnt++;
         start0 = (k == 0);
      end
      start0 = 1'b0;
   endtask

   task automatic test_ignored_start();
      int ndone;
      ndone = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (dn0) ndone++;
         tot_cnt++;
         if (obs0 !== exp_at(k, 2, OVR && k >= 6))
            $display("FAIL ignored[%0d] got %h want %h", k, obs0, exp_at(k, 2, OVR && k >= 6));
         else pass_cnt++;
         start0 = (k == 0 || k == 5 || k == 13);
      end
      start0 = 1'b0;
      tot_cnt++;
      if (ndone !== 1) $display("FAIL done_count got %0d want 1", ndone);
      else pass_cnt++;
      // Accepted start with clear_ovr drops the sticky flag.
      @(negedge clk);
      tot_cnt++;
      if (ov0 !== OVR) $display("FAIL ovr_before_clear got %b want %b", ov0, OVR);
      else pass_cnt++;
      start0 = 1'b1; clr0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; clr0 = 1'b0;
      tot_cnt++;
      if ({ov0, uk0} !== 2'b01) $display("FAIL ovr_clear got %b want 01", {ov0, uk0});
      else pass_cnt++;
      repeat (14) @(negedge clk);
   endtask

   task automatic test_midreset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         tot_cnt++;
         if (obs0 !== exp_at(k, 2, 1'b0))
            $display("FAIL pre_reset[%0d] got %h want %h", k, obs0, exp_at(k, 2, 1'b0));
         else pass_cnt++;
         start0 = (k == 0);
      end
      start0 = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      tot_cnt++;
      if (obs0 !== 18'd0) $display("FAIL async_reset got %h want %h", obs0, 18'd0);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      test_single();
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 28; k++) begin
         @(negedge clk);
         tot_cnt++;
         if (obs1 !== exp_at(k % 9, 1, 1'b0))
            $display("FAIL b2b[%0d] got %h want %h", k, obs1, exp_at(k % 9, 1, 1'b0));
         else pass_cnt++;
         tot_cnt++;
         if (int'(a11) + int'(a21) + int'(a31) > 1 || (fk1e && yk1))
            $display("FAIL b2b_overlap[%0d] got acum=%b%b%b fk=%b yk=%b want exclusive",
                     k, a11, a21, a31, fk1e, yk1);
         else pass_cnt++;
         start1 = (k % 9 == 0) && (k < 27);
      end
      start1 = 1'b0;
   endtask

   task automatic test_datapath();
      longint gy[32];
      longint f, f1, f2, u;
      f1 = 0; f2 = 0;
      for (int n = 0; n < 32; n++) begin
         u = (n == 0) ? 64'sd16384 : 64'sd0;
         f = u + ((A1 * f1) >>> 14) + ((A2 * f2) >>> 14);
         gy[n] = ((B0 * f) >>> 14) + ((B1 * f1) >>> 14) + ((B2 * f2) >>> 14);
         f2 = f1; f1 = f;
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 32; n++) begin
         for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (k == 13) begin
               tot_cnt++;
               if (dn0 !== 1'b1) $display("FAIL dp_done[%0d] got %b want 1", n, dn0);
               else pass_cnt++;
               tot_cnt++;
               if (yk_r !== gy[n]) $display("FAIL dp_yk[%0d] got %0d want %0d", n, yk_r, gy[n]);
               else pass_cnt++;
            end
            start0 = (k == 0);
            uk_in = (n == 0 && k < 2) ? 64'sd16384 : 64'sd0;
         end
      end
      start0 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_ignored_start();
      test_midreset();
      test_back_to_back();
      test_datapath();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end
endmodule

// File: doc/biquad_seq_ctrl.md
Name: biquad_seq_ctrl

Overview:
- Sequencer FSM for the shared multiply-accumulate datapath of the IIR biquad.
- Per input sample, drives the coefficient select (controlS), the state-sample select (controlC) and the addend select (controlZ) through the five MAC steps.
- Issues the register-load strobes for acum1/acum2/acum3, fk, yk and the fk delay line.
- Sits between the sample-rate tick source and the mux/multiplier/adder datapath.

Parameters:
- STEP_CYC, 2: cycles each MAC step holds its selects (covers multiplier+adder settle); legal 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- start  in  1  one-cycle sample tick; Uk valid on the same cycle
- controlS  out  3  coefficient select: 000=0, 001=a1, 010=a2, 011=b0, 100=b1, 101=b2
- controlC  out  2  sample select: 00=0, 01=fk1, 10=fk2, 11=fk
- controlZ  out  3  addend select: 000=0, 001=Uk, 010=yk, 011=acum1, 100=acum2, 101=acum3
- en_uk  out  1  load Uk input register
- en_acum1, en_acum2, en_acum3  out  1 each  load accumulator from adder sum
- en_fk  out  1  load fk from adder sum
- en_yk  out  1  load yk from adder sum
- shift_en  out  1  fk2<=fk1, fk1<=fk
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse; yk valid
- overrun  out  1  sticky error flag (optional feature only; tied 0 otherwise)

Behaviour:
- All outputs are registered Moore outputs decoded from the current state.
- Reset (any time, including mid-sequence): state=IDLE, step counter=0, all selects 000/00, all strobes 0, busy=0, done=0, overrun=0.
- States: IDLE -> CAPTURE -> S0 -> S1 -> S2 -> S3 -> S4 -> UPDATE -> DONE -> IDLE.
- IDLE: selects 0. Moves to CAPTURE on start=1.
- CAPTURE, 1 cycle: en_uk=1.
- Each step Sx lasts exactly STEP_CYC cycles.
  - Selects are held constant for the whole step.
  - Strobes are asserted only on the last cycle of the step.
  - The step counter clears on entry to each step.
- Step table (S,C,Z ; strobes on last cycle):
  - S0: 001,01,001 (Uk + a1*fk1) ; en_acum1
  - S1: 010,10,011 (acum1 + a2*fk2) ; en_acum2, en_fk
  - S2: 011,11,000 (b0*fk) ; en_acum1
  - S3: 100,01,011 (acum1 + b1*fk1) ; en_acum2
  - S4: 101,10,100 (acum2 + b2*fk2) ; en_acum3, en_yk
- UPDATE, 1 cycle: shift_en=1, selects 0.
- DONE, 1 cycle: done=1, then IDLE.
- Latency: done is high 3+5*STEP_CYC cycles after the start cycle (13 at default).
- Minimum start spacing is 4+5*STEP_CYC cycles.
- start while busy=1 (including the DONE cycle) is ignored; the sequence is not restarted or altered.
- Unused select codes (110, 111) are never driven.
- At most one of en_acum1/2/3 is high in any cycle.
- en_fk and en_yk never coincide.

Optional Feature:
- Macro: BIQUAD_CTRL_OVERRUN_EN.
- Defined:
  - overrun sets to 1 on any cycle with start=1 and busy=1.
  - It stays set until reset, or until a start accepted in IDLE while the separate clear_ovr input is 1.
  - clear_ovr is a 1-bit input that exists only when the macro is defined.
- Undefined: no clear_ovr port; overrun is constant 0; ignored starts leave no trace.

Test Plan:
- Reset then idle 20 cycles -> all selects 0, strobes 0, busy=0, done=0.
- Single start, STEP_CYC=2:
  - en_uk at cycle 1.
  - (S,C,Z) = (001,01,001) in cycles 2-3, with en_acum1 in cycle 3.
  - Later steps follow the step table in 2-cycle steps.
  - en_fk in cycle 5, en_yk in cycle 11, shift_en in cycle 12, done in cycle 13, busy low in cycle 14.
- Start pulses at cycles 0, 5 and 13 -> the second and third are ignored; exactly one done (cycle 13); with the macro, overrun=1 from cycle 6.
- Reset asserted low during S2 -> outputs 0 immediately; next start produces a full, correct 13-cycle sequence.
- STEP_CYC=1 with back-to-back starts every 9 cycles -> done every 9 cycles; no strobe overlap.
- Datapath co-sim with a1=16957, a2=-6026, b0=9841, b1=-19677, b2=9841 and a unit impulse Uk -> yk matches the golden direct-form-II model for 32 samples.
